// File: rtl/exec_pkg.sv
// Shared widths and FSM state encoding for the execution dispatcher.
package exec_pkg;

    localparam int unsigned INST_W  = 6;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SHIFT_W = 5;
    localparam int unsigned DEST_W  = 5;
    localparam int unsigned CNT_W   = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/dispatch_timer.sv
// Loadable saturating up-counter with a terminal-count compare, shared by the ARM and WAIT phases.
module dispatch_timer
    import exec_pkg::*;
#(
    parameter int unsigned W = CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] tc_value,
    output logic [W-1:0] count,
    output logic         tc_c
);

    // Count register: clear has priority, increments stop at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

    assign tc_c = (count == tc_value);

endmodule

// File: rtl/exec_dispatch.sv
// Issues one operation at a time to an execution element, waits for its result, and hands it to writeback.
module exec_dispatch
    import exec_pkg::*;
#(
    parameter int unsigned ARM_CYCLES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [INST_W-1:0]  req_inst_num,
    input  logic [DATA_W-1:0]  req_const16_x,
    input  logic [SHIFT_W-1:0] req_shift5,
    input  logic [DATA_W-1:0]  req_rs,
    input  logic [DATA_W-1:0]  req_rt,
    input  logic [DEST_W-1:0]  req_dest,
    output logic [INST_W-1:0]  elem_inst_num,
    output logic [DATA_W-1:0]  elem_const16_x,
    output logic [SHIFT_W-1:0] elem_shift5,
    output logic [DATA_W-1:0]  elem_rs,
    output logic [DATA_W-1:0]  elem_rt,
    output logic               elem_reset,
    input  logic               elem_completed,
    input  logic [DATA_W-1:0]  elem_out,
    output logic               wb_valid,
    input  logic               wb_ready,
    output logic [DATA_W-1:0]  wb_data,
    output logic [DEST_W-1:0]  wb_dest,
    output logic               wb_error
);

    localparam logic [CNT_W-1:0] ARM_TC = CNT_W'(ARM_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_TC  = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    state_t           next_state;
    logic             accept_c;
    logic             complete_c;
    logic             timeout_c;
    logic             tmr_clear_c;
    logic             tmr_enable_c;
    logic [CNT_W-1:0] tmr_value_c;
    logic [CNT_W-1:0] tmr_count;
    logic             tmr_tc_c;

    assign req_ready = (state == ST_IDLE) && !reset;

    dispatch_timer #(
        .W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (tmr_clear_c),
        .enable   (tmr_enable_c),
        .tc_value (tmr_value_c),
        .count    (tmr_count),
        .tc_c     (tmr_tc_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and control strobes; the first WAIT cycle (count 0) never qualifies completion.
    always_comb begin
        next_state   = state;
        accept_c     = 1'b0;
        complete_c   = 1'b0;
        timeout_c    = 1'b0;
        tmr_clear_c  = 1'b0;
        tmr_enable_c = 1'b0;
        tmr_value_c  = TO_TC;
        case (state)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    accept_c    = 1'b1;
                    tmr_clear_c = 1'b1;
                    next_state  = ST_ARM;
                end
            end
            ST_ARM: begin
                tmr_value_c  = ARM_TC;
                tmr_enable_c = 1'b1;
                if (tmr_tc_c) begin
                    tmr_clear_c = 1'b1;
                    next_state  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                tmr_enable_c = 1'b1;
                if (elem_completed && (tmr_count != '0)) begin
                    complete_c = 1'b1;
                    next_state = ST_DONE;
                end else if (tmr_tc_c) begin
                    timeout_c  = 1'b1;
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if (wb_ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
        if (reset) begin
            next_state = ST_IDLE;
        end
    end

    // Registered operands, element control and writeback payload.
    always_ff @(posedge clk) begin
        if (reset) begin
            elem_inst_num  <= '0;
            elem_const16_x <= '0;
            elem_shift5    <= '0;
            elem_rs        <= '0;
            elem_rt        <= '0;
            elem_reset     <= 1'b1;
            wb_valid       <= 1'b0;
            wb_data        <= '0;
            wb_dest        <= '0;
            wb_error       <= 1'b0;
        end else begin
            elem_reset <= (next_state != ST_WAIT);
            wb_valid   <= (next_state == ST_DONE);
            if (accept_c) begin
                elem_inst_num  <= req_inst_num;
                elem_const16_x <= req_const16_x;
                elem_shift5    <= req_shift5;
                elem_rs        <= req_rs;
                elem_rt        <= req_rt;
                wb_dest        <= req_dest;
            end
            if (complete_c) begin
                wb_data  <= elem_out;
                wb_error <= 1'b0;
            end else if (timeout_c) begin
                wb_data  <= '0;
                wb_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_exec_dispatch.sv
// Directed scoreboard bench for exec_dispatch with a behavioural execution element.
module tb_exec_dispatch;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_inst_num;
    logic [31:0] req_const16_x;
    logic [4:0]  req_shift5;
    logic [31:0] req_rs;
    logic [31:0] req_rt;
    logic [4:0]  req_dest;
    logic [5:0]  elem_inst_num;
    logic [31:0] elem_const16_x;
    logic [4:0]  elem_shift5;
    logic [31:0] elem_rs;
    logic [31:0] elem_rt;
    logic        elem_reset;
    logic        elem_completed;
    logic [31:0] elem_out;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_dest;
    logic        wb_error;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  dest;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Element model controls: 0 = complete after comp_delay low-reset cycles, 1 = tied high, 2 = tied low.
    logic [1:0] comp_mode = 2'd0;
    int         comp_delay = 3;
    int         wait_cnt = 0;

    exec_dispatch #(
        .ARM_CYCLES     (2),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_inst_num   (req_inst_num),
        .req_const16_x  (req_const16_x),
        .req_shift5     (req_shift5),
        .req_rs         (req_rs),
        .req_rt         (req_rt),
        .req_dest       (req_dest),
        .elem_inst_num  (elem_inst_num),
        .elem_const16_x (elem_const16_x),
        .elem_shift5    (elem_shift5),
        .elem_rs        (elem_rs),
        .elem_rt        (elem_rt),
        .elem_reset     (elem_reset),
        .elem_completed (elem_completed),
        .elem_out       (elem_out),
        .wb_valid       (wb_valid),
        .wb_ready       (wb_ready),
        .wb_data        (wb_data),
        .wb_dest        (wb_dest),
        .wb_error       (wb_error)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] elem_calc(input logic [5:0] inst, input logic [31:0] c,
                                              input logic [4:0] sh, input logic [31:0] a,
                                              input logic [31:0] b);
        case (inst)
            6'd8:    return a + b;
            6'd9:    return a - b;
            6'd12:   return a & b;
            6'd15:   return {c[15:0], 16'h0000};
            default: return a << sh;
        endcase
    endfunction

    // Element: cycles since its reset was released.
    always @(posedge clk) begin
        if (elem_reset) wait_cnt <= 0;
        else            wait_cnt <= wait_cnt + 1;
    end

    assign elem_completed = (comp_mode == 2'd1) ? 1'b1 :
                            (comp_mode == 2'd2) ? 1'b0 : (wait_cnt >= comp_delay);
    assign elem_out = elem_calc(elem_inst_num, elem_const16_x, elem_shift5, elem_rs, elem_rt);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [5:0] inst, input logic [31:0] c, input logic [4:0] sh,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] dest,
                        input logic push, input logic [31:0] exp_data, input logic exp_err,
                        output int cyc);
        exp_t e;
        logic took;
        took          = 1'b0;
        cyc           = 0;
        req_inst_num  = inst;
        req_const16_x = c;
        req_shift5    = sh;
        req_rs        = a;
        req_rt        = b;
        req_dest      = dest;
        req_valid     = 1'b1;
        if (push) begin
            e.data = exp_data;
            e.dest = dest;
            e.err  = exp_err;
            sb.push_back(e);
        end
        while (cyc < 300 && !took) begin
            took = req_ready;
            step();
            cyc++;
        end
        req_valid = 1'b0;
        if (!took) chk("accept_timeout", 32'(took), 32'd1);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 300 && sb.size() != 0; i++) step();
        chk(tag, 32'(sb.size()), 32'd0);
    endtask

    task automatic wait_wb_valid(input string tag);
        for (int i = 0; i < 300 && !wb_valid; i++) step();
        chk(tag, 32'(wb_valid), 32'd1);
    endtask

    // Scoreboard: compare each writeback at its handshake against the oldest expectation.
    always @(negedge clk) begin : wb_monitor
        exp_t e;
        if (!reset && wb_valid && wb_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_wb", 32'(wb_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("wb_data", wb_data, e.data);
                chk("wb_dest", 32'(wb_dest), 32'(e.dest));
                chk("wb_error", 32'(wb_error), 32'(e.err));
                chk("wb_no_overlap", 32'(elem_reset), 32'd1);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int cyc;
        int waitc;
        reset         = 1'b1;
        req_valid     = 1'b0;
        req_inst_num  = '0;
        req_const16_x = '0;
        req_shift5    = '0;
        req_rs        = '0;
        req_rt        = '0;
        req_dest      = '0;
        wb_ready      = 1'b0;
        repeat (3) step();

        // Reset values
        chk("rst_elem_reset", 32'(elem_reset), 32'd1);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_error", 32'(wb_error), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_wb_dest", 32'(wb_dest), 32'd0);
        chk("rst_elem_inst", 32'(elem_inst_num), 32'd0);
        chk("rst_elem_const", elem_const16_x, 32'd0);
        chk("rst_elem_shift", 32'(elem_shift5), 32'd0);
        chk("rst_elem_rs", elem_rs, 32'd0);
        chk("rst_elem_rt", elem_rt, 32'd0);
        reset = 1'b0;
        #1;
        chk("ready_after_reset", 32'(req_ready), 32'd1);

        // ADD with completion 3 cycles into WAIT
        wb_ready   = 1'b1;
        comp_mode  = 2'd0;
        comp_delay = 3;
        send(6'd8, 32'd0, 5'd0, 32'd17, 32'd255, 5'd5, 1'b1, 32'd272, 1'b0, cyc);
        chk("first_accept_cycles", 32'(cyc), 32'd1);
        chk("add_elem_inst", 32'(elem_inst_num), 32'd8);
        chk("add_elem_rs", elem_rs, 32'd17);
        chk("add_elem_rt", elem_rt, 32'd255);
        chk("add_busy_ready", 32'(req_ready), 32'd0);
        drain("add_drain");
        chk("add_wb_drop", 32'(wb_valid), 32'd0);

        // Arm timing with completion tied high
        comp_mode = 2'd1;
        send(6'd8, 32'd0, 5'd0, 32'd1, 32'd2, 5'd7, 1'b1, 32'd3, 1'b0, cyc);
        chk("arm_cycle1", 32'(elem_reset), 32'd1);
        step();
        chk("arm_cycle2", 32'(elem_reset), 32'd1);
        step();
        chk("wait1_elem_reset", 32'(elem_reset), 32'd0);
        chk("wait1_wb_valid", 32'(wb_valid), 32'd0);
        step();
        chk("wait2_elem_reset", 32'(elem_reset), 32'd0);
        chk("wait2_wb_valid", 32'(wb_valid), 32'd0);
        step();
        chk("arm_done_valid", 32'(wb_valid), 32'd1);
        chk("arm_done_elem_reset", 32'(elem_reset), 32'd1);
        drain("arm_drain");

        // Timeout with completion tied low
        comp_mode = 2'd2;
        send(6'd8, 32'd0, 5'd0, 32'd5, 32'd6, 5'd3, 1'b1, 32'd0, 1'b1, cyc);
        waitc = 0;
        for (int i = 0; i < 300 && !wb_valid; i++) begin
            if (!elem_reset) waitc++;
            step();
        end
        chk("timeout_wait_cycles", 32'(waitc), 32'd64);
        chk("timeout_error", 32'(wb_error), 32'd1);
        chk("timeout_data", wb_data, 32'd0);
        chk("timeout_elem_reset", 32'(elem_reset), 32'd1);
        drain("timeout_drain");

        // SUB under writeback backpressure
        wb_ready   = 1'b0;
        comp_mode  = 2'd0;
        comp_delay = 2;
        send(6'd9, 32'd0, 5'd0, 32'ha9876543, 32'h98765432, 5'd17, 1'b1, 32'h11111111, 1'b0, cyc);
        wait_wb_valid("bp_wait_valid");
        for (int i = 0; i < 5; i++) begin
            chk("bp_data", wb_data, 32'h11111111);
            chk("bp_valid", 32'(wb_valid), 32'd1);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            step();
        end
        wb_ready = 1'b1;
        drain("bp_drain");
        chk("bp_after_valid", 32'(wb_valid), 32'd0);
        chk("bp_after_ready", 32'(req_ready), 32'd1);

        // Reset in the middle of WAIT
        comp_mode = 2'd2;
        send(6'd8, 32'd0, 5'd0, 32'd9, 32'd9, 5'd9, 1'b0, 32'd0, 1'b0, cyc);
        for (int i = 0; i < 20 && elem_reset; i++) step();
        chk("mid_in_wait", 32'(elem_reset), 32'd0);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("mid_rst_elem_reset", 32'(elem_reset), 32'd1);
        chk("mid_rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
        comp_mode  = 2'd0;
        comp_delay = 1;
        send(6'd12, 32'd0, 5'd0, 32'h0000f0f0, 32'h0000ff00, 5'd11, 1'b1, 32'h0000f000, 1'b0, cyc);
        chk("mid_rst_accept_cycles", 32'(cyc), 32'd1);
        drain("mid_rst_drain");

        // Back-to-back LUI then AND
        comp_delay = 1;
        send(6'd15, 32'h000035f1, 5'd0, 32'd0, 32'd0, 5'd1, 1'b1, 32'h35f10000, 1'b0, cyc);
        send(6'd12, 32'd0, 5'd0, 32'd3, 32'd5, 5'd2, 1'b1, 32'd1, 1'b0, cyc);
        chk("b2b_interval", 32'(cyc), 32'd6);
        drain("b2b_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/exec_dispatch.md
EXEC_DISPATCH -- requirements
Module: exec_dispatch

Interface
REQ-001 Parameter ARM_CYCLES, default 2: number of cycles elem_reset is held high before each operation.
REQ-002 Parameter TIMEOUT_CYCLES, default 64: maximum number of WAIT cycles before the operation is aborted.
REQ-003 Port clk, input, 1: the single clock; every flop updates on the rising edge.
REQ-004 Port reset, input, 1: reset is synchronous and active-high.
REQ-005 Port req_valid / req_ready, input / output, 1 each: issue handshake; transfer occurs when both are high at a rising edge.
REQ-006 Port req_inst_num, input, 6: instruction number.
REQ-007 Port req_const16_x, input, 32: extended immediate.
REQ-008 Port req_shift5, input, 5: shift amount.
REQ-009 Port req_rs / req_rt, input, 32 each: source operands.
REQ-010 Port req_dest, input, 5: destination register tag.
REQ-011 Ports elem_inst_num (6), elem_const16_x (32), elem_shift5 (5), elem_rs (32), elem_rt (32), output: operands driven to the execution element.
REQ-012 Port elem_reset, output, 1: execution-element reset and start control; its falling edge starts the operation.
REQ-013 Port elem_completed, input, 1: level signal from the element; high means the result is ready.
REQ-014 Port elem_out, input, 32: element result.
REQ-015 Port wb_valid / wb_ready, output / input, 1 each: writeback handshake.
REQ-016 Ports wb_data (32), wb_dest (5), wb_error (1), output: writeback payload.

Function
REQ-017 States SHALL be IDLE, ARM, WAIT and DONE.
REQ-018 req_ready SHALL be 1 only in IDLE with reset low.
REQ-019 On acceptance, all operands and req_dest SHALL be registered into elem_* and the destination register, and the state SHALL go to ARM.
REQ-020 Registered operands SHALL stay stable until the next acceptance.
REQ-021 elem_reset SHALL be 1 in IDLE, ARM and DONE, and 0 only in WAIT.
REQ-022 Timing from acceptance at edge T:
- ARM occupies exactly ARM_CYCLES cycles (T+1..T+ARM_CYCLES).
- WAIT begins at cycle T+ARM_CYCLES+1.
REQ-023 elem_completed SHALL be ignored in IDLE, ARM and DONE.
REQ-024 elem_completed SHALL be sampled in WAIT only from the second WAIT cycle onward, so a stale completed level is not accepted.
REQ-025 On a qualifying completed in WAIT: capture elem_out into wb_data, set wb_error=0, go to DONE; wb_valid is high in the next cycle.
REQ-026 A 7-bit timeout counter SHALL clear on entry to WAIT and increment on each WAIT cycle.
REQ-027 When the count reaches TIMEOUT_CYCLES without completion, the block SHALL go to DONE with wb_data=0 and wb_error=1.
REQ-028 If completion and timeout occur in the same cycle, completion SHALL win.
REQ-029 In DONE, wb_valid SHALL be 1, and wb_data, wb_dest and wb_error SHALL be stable until wb_ready is high.
REQ-030 On wb_valid and wb_ready both high, the block SHALL return to IDLE, with wb_valid=0 the next cycle.
REQ-031 The block SHALL hold at most one operation in flight; minimum issue-to-issue interval is ARM_CYCLES+4 cycles.
REQ-032 Counters SHALL saturate and never wrap.

Reset
REQ-033 While reset is high, the next state SHALL be IDLE from any state, abandoning any operation in progress.
REQ-034 Reset values SHALL be:
- elem_reset=1, req_ready=0, wb_valid=0, wb_error=0.
- wb_data=0, wb_dest=0, all elem_* operands=0, both counters=0.
REQ-035 The first acceptance SHALL be possible on the first edge after reset goes low.

Structure
REQ-036 Package exec_pkg SHALL hold the state enum, the inst_num width (6) and the operand width (32).
REQ-037 Sub-module dispatch_timer SHALL be used: a loadable saturating counter with a terminal-count flag, shared by ARM and WAIT.
REQ-038 All outputs SHALL be registered except req_ready, which is decoded from state.

Verification
REQ-039 ADD: inst 8, rs=17, rt=255, element model completes 3 cycles after WAIT entry -> wb_data=272, wb_error=0, wb_dest echoed.
REQ-040 Arm timing: with elem_completed tied high, elem_reset is high exactly 2 cycles after acceptance, and completion is taken on the 2nd WAIT cycle, not the 1st.
REQ-041 Timeout: elem_completed tied low -> wb_valid with wb_error=1 and wb_data=0 after 64 WAIT cycles, and elem_reset returns to 1.
REQ-042 Backpressure: SUB rs=32'ha9876543, rt=32'h98765432 with wb_ready low for 5 cycles -> wb_data=32'h11111111 held stable, req_ready=0, then handshake completes.
REQ-043 Reset mid-WAIT: assert reset for 1 cycle -> next cycle IDLE, elem_reset=1, wb_valid never asserted, and a new request is accepted the following cycle.
REQ-044 Back-to-back: two requests (LUI const 16'h35f1, then AND 3&5) -> results 32'h35f10000 then 1, in order, with no overlap.
